// File: rtl/ahb2_mem_ws_if.sv
// ---------------------------------------------------------------------------
// ahb2_mem_ws_if
//   AHB2 (AHB-Lite) signal bundle between a bus master/interconnect and the
//   ahb2_mem_ws memory slave.
//
//   Parameters
//     DATA_WIDTH : width of hwdata/hrdata (32 or 64)
//
//   Signals
//     hsel     : slave select
//     haddr    : byte address
//     htrans   : IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//     hwrite   : 1 = write
//     hsize    : transfer size, log2 of bytes
//     hburst   : burst type (not used by the memory)
//     hwdata   : write data, valid in the data phase
//     hreadyi  : bus HREADY as seen by the slave
//     hrdata   : read data
//     hreadyo  : slave HREADY
//     hresp    : OKAY=0, ERROR=1
// ---------------------------------------------------------------------------
interface ahb2_mem_ws_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyi;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyo;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyi,
    input  hrdata, hreadyo, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyi,
    output hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_mem_ws.sv
// ---------------------------------------------------------------------------
// ahb2_mem_ws
//   AHB2 (AHB-Lite) memory slave with configurable data width, byte-lane
//   writes derived from hsize/haddr, programmable wait states and a
//   two-cycle ERROR response for out-of-range, oversized or misaligned
//   transfers.
//
//   Parameters
//     ADDR_WIDTH  : byte-address bits decoded; memory is 2**ADDR_WIDTH bytes
//     DATA_WIDTH  : bus data width, 32 or 64
//     WAIT_STATES : extra data-phase cycles per OKAY transfer, 0..7
//
//   Ports
//     clk   : clock
//     rst_n : synchronous, active-low reset
//     bus   : AHB slave bundle (see ahb2_mem_ws_if)
//
//   Backdoor tasks for simulation: init_mem, init_mem_with_addr,
//   read_word(addr, data), write_word(addr, data). They index the array with
//   addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
// ---------------------------------------------------------------------------
module ahb2_mem_ws #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ahb2_mem_ws_if.slave      bus
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam int WORDS     = 1 << IDX_W;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [WORDS];

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_e                state_q;
  logic [2:0]            cnt_q;
  logic                  hreadyo_q;
  logic [1:0]            hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [DATA_WIDTH-1:0] rd_buf_q;   // read word captured at accept
  logic                  wr_pend_q;  // write accepted, data phase open
  logic                  rd_pend_q;  // read accepted, data phase open
  logic [IDX_W-1:0]      word_q;
  logic [BYTES-1:0]      be_q;

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic                  acc;
  logic                  range_err;
  logic                  size_err;
  logic                  align_err;
  logic                  xfer_err;
  logic [7:0]            align_mask;
  logic [IDX_W-1:0]      word_idx;
  logic [BYTES-1:0]      size_fill;
  logic [BYTES-1:0]      be;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  assign acc = bus.hsel & bus.htrans[1] & bus.hreadyi;

  assign range_err  = (bus.haddr >> ADDR_WIDTH) != 32'd0;
  assign size_err   = bus.hsize > 3'(LANE_BITS);
  assign align_mask = (8'd1 << bus.hsize) - 8'd1;
  assign align_err  = |(bus.haddr[7:0] & align_mask);
  assign xfer_err   = range_err | size_err | align_err;

  assign word_idx = bus.haddr[ADDR_WIDTH-1:LANE_BITS];

  // Lane mask: 2**hsize ones, shifted up to the addressed byte lane.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    size_fill = '0;
    for (int b = 0; b < BYTES; b++) begin
      size_fill[b] = (b < (1 << bus.hsize));
    end
  end

  assign be = size_fill << bus.haddr[LANE_BITS-1:0];

  // A pending write lands on the edge that ends its completing cycle, which
  // is the only cycle the FSM sits in IDLE with the write still open.
  assign wr_commit = wr_pend_q && (state_q == ST_IDLE);

  // Read word with forwarding: when a write commits on the same edge that
  // accepts a read of the same word, the read sees the merged result.
  always_comb begin
    rd_word = mem[word_idx];
    if (wr_commit && (word_q == word_idx)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) rd_word[b*8 +: 8] = bus.hwdata[b*8 +: 8];
      end
    end
  end

  // hburst and the BUSY/SEQ distinction do not affect a memory.
  assign unused_ok = ^{bus.hburst, bus.htrans[0]};

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      hreadyo_q <= 1'b1;
      hresp_q   <= RESP_OKAY;
      hrdata_q  <= '0;
      rd_buf_q  <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      word_q    <= '0;
      be_q      <= '0;
    end else begin
      // hrdata is non-zero only in a completing read data phase.
      hrdata_q <= '0;

      case (state_q)
        // ERR2 is the completing cycle of an error; a new accept there is
        // handled exactly as in IDLE.
        ST_IDLE, ST_ERR2: begin
          state_q   <= ST_IDLE;
          hreadyo_q <= 1'b1;
          hresp_q   <= RESP_OKAY;
          wr_pend_q <= 1'b0;
          rd_pend_q <= 1'b0;
          if (acc) begin
            if (xfer_err) begin
              state_q   <= ST_ERR1;
              hreadyo_q <= 1'b0;
              hresp_q   <= RESP_ERROR;
            end else begin
              word_q    <= word_idx;
              be_q      <= be;
              wr_pend_q <= bus.hwrite;
              rd_pend_q <= ~bus.hwrite;
              if (WAIT_STATES == 0) begin
                if (!bus.hwrite) hrdata_q <= rd_word;
              end else begin
                state_q   <= ST_WAIT;
                cnt_q     <= 3'(WAIT_STATES);
                hreadyo_q <= 1'b0;
                rd_buf_q  <= rd_word;
              end
            end
          end
        end

        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q   <= ST_IDLE;
            hreadyo_q <= 1'b1;
            if (rd_pend_q) hrdata_q <= rd_buf_q;
          end
        end

        ST_ERR1: begin
          state_q   <= ST_ERR2;
          hreadyo_q <= 1'b1;
          hresp_q   <= RESP_ERROR;
        end

        default: begin
          state_q   <= ST_IDLE;
          hreadyo_q <= 1'b1;
          hresp_q   <= RESP_OKAY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Array write port. hwdata is sampled only on the completing edge; a reset
  // edge suppresses the write so an aborted transfer leaves the array intact.
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it would cost a write to every
  // word, and its contents are meant to survive a bus reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem[word_q][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
      end
    end
  end

  assign bus.hreadyo = hreadyo_q;
  assign bus.hresp   = hresp_q;
  assign bus.hrdata  = hrdata_q;

  // -------------------------------------------------------------------------
  // Backdoor access for benches
  // -------------------------------------------------------------------------
  task automatic init_mem();
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = '0;
    end
  endtask

  // Each word holds its own byte address, handy for spotting decode errors.
  task automatic init_mem_with_addr();
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = DATA_WIDTH'(i << LANE_BITS);
    end
  endtask

  task automatic read_word(input logic [31:0] addr,
                           output logic [DATA_WIDTH-1:0] data);
    data = mem[addr[ADDR_WIDTH-1:LANE_BITS]];
  endtask

  task automatic write_word(input logic [31:0] addr,
                            input logic [DATA_WIDTH-1:0] data);
    mem[addr[ADDR_WIDTH-1:LANE_BITS]] = data;
  endtask

endmodule

// File: tb/tb_ahb2_mem_ws.sv
// ---------------------------------------------------------------------------
// tb_ahb2_mem_ws
//   Directed bench for ahb2_mem_ws. Four instances share one set of address
//   and write-data drivers and are told apart by hsel:
//     u_a : ADDR_WIDTH=18, DATA_WIDTH=32, WAIT_STATES=0
//     u_b : ADDR_WIDTH=12, DATA_WIDTH=32, WAIT_STATES=2
//     u_c : ADDR_WIDTH=12, DATA_WIDTH=32, WAIT_STATES=3 (own reset)
//     u_d : ADDR_WIDTH=12, DATA_WIDTH=64, WAIT_STATES=0
//   Each slave sits alone on its bus, so its hreadyi is its own hreadyo.
//   Inputs change 1 time unit after the rising edge (or on the falling edge
//   inside a data phase); outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb2_mem_ws;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_c_n;

  always #5 clk = ~clk;

  // Shared stimulus
  logic [3:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic [1:0]  tgt;

  // Observed outputs of the targeted instance
  logic [63:0] o_rdata;
  logic        o_ready;
  logic [1:0]  o_resp;

  int n_total = 0;
  int n_bad   = 0;

  ahb2_mem_ws_if #(.DATA_WIDTH(32)) bus_a ();
  ahb2_mem_ws_if #(.DATA_WIDTH(32)) bus_b ();
  ahb2_mem_ws_if #(.DATA_WIDTH(32)) bus_c ();
  ahb2_mem_ws_if #(.DATA_WIDTH(64)) bus_d ();

  assign bus_a.hsel = sel[0];
  assign bus_b.hsel = sel[1];
  assign bus_c.hsel = sel[2];
  assign bus_d.hsel = sel[3];

  assign bus_a.haddr = haddr;  assign bus_b.haddr = haddr;
  assign bus_c.haddr = haddr;  assign bus_d.haddr = haddr;
  assign bus_a.htrans = htrans; assign bus_b.htrans = htrans;
  assign bus_c.htrans = htrans; assign bus_d.htrans = htrans;
  assign bus_a.hwrite = hwrite; assign bus_b.hwrite = hwrite;
  assign bus_c.hwrite = hwrite; assign bus_d.hwrite = hwrite;
  assign bus_a.hsize = hsize;  assign bus_b.hsize = hsize;
  assign bus_c.hsize = hsize;  assign bus_d.hsize = hsize;
  assign bus_a.hburst = 3'd0;  assign bus_b.hburst = 3'd0;
  assign bus_c.hburst = 3'd0;  assign bus_d.hburst = 3'd0;
  assign bus_a.hwdata = hwdata[31:0];
  assign bus_b.hwdata = hwdata[31:0];
  assign bus_c.hwdata = hwdata[31:0];
  assign bus_d.hwdata = hwdata;
  assign bus_a.hreadyi = bus_a.hreadyo;
  assign bus_b.hreadyi = bus_b.hreadyo;
  assign bus_c.hreadyi = bus_c.hreadyo;
  assign bus_d.hreadyi = bus_d.hreadyo;

  ahb2_mem_ws #(.ADDR_WIDTH(18), .DATA_WIDTH(32), .WAIT_STATES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  ahb2_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  ahb2_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3)) u_c (
    .clk(clk), .rst_n(rst_c_n), .bus(bus_c));
  ahb2_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .WAIT_STATES(0)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d));

  always_comb begin
    o_rdata = '0;
    o_ready = 1'b0;
    o_resp  = 2'b00;
    case (tgt)
      2'd0: begin o_rdata = {32'h0, bus_a.hrdata}; o_ready = bus_a.hreadyo; o_resp = bus_a.hresp; end
      2'd1: begin o_rdata = {32'h0, bus_b.hrdata}; o_ready = bus_b.hreadyo; o_resp = bus_b.hresp; end
      2'd2: begin o_rdata = {32'h0, bus_c.hrdata}; o_ready = bus_c.hreadyo; o_resp = bus_c.hresp; end
      default: begin o_rdata = bus_d.hrdata; o_ready = bus_d.hreadyo; o_resp = bus_d.hresp; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sel    = 4'b0000;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'd0;
  endtask

  task automatic addr_phase(input logic [1:0] t, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    tgt    = t;
    sel    = 4'b0001 << t;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  // One isolated transfer. During wait cycles hwdata carries junk; the real
  // write data appears only in the cycle where hreadyo is seen high.
  task automatic xfer(input logic [1:0] t, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [63:0] wdata,
                      output logic [63:0] rdata, output int nwait,
                      output logic [1:0] resp_first, output logic [1:0] resp_last,
                      output logic [63:0] wait_rd);
    addr_phase(t, wr, addr, size);
    cyc();
    bus_idle();
    nwait   = 0;
    wait_rd = '0;
    @(negedge clk);
    resp_first = o_resp;
    while (!o_ready && nwait < 16) begin
      wait_rd = wait_rd | o_rdata;
      hwdata  = 64'h0000_0000_0000_DEAD;
      nwait++;
      @(negedge clk);
    end
    if (nwait >= 16) check("xfer_timeout", 64'(nwait), 64'd0);
    hwdata    = wdata;
    rdata     = o_rdata;
    resp_last = o_resp;
    cyc();
    hwdata = '0;
  endtask

  logic [63:0] rd;
  logic [63:0] wrd;
  logic [1:0]  r0, r1;
  int          nw;
  logic [31:0] d32;
  logic [63:0] d64;

  initial begin
    rst_n   = 1'b0;
    rst_c_n = 1'b0;
    hwdata  = '0;
    tgt     = 2'd0;
    bus_idle();
    u_a.init_mem();
    u_b.init_mem();
    u_c.init_mem();
    u_d.init_mem();
    repeat (2) cyc();

    // ---- reset state -------------------------------------------------------
    @(negedge clk);
    tgt = 2'd0;
    #0;
    check("rst_a_ready", 64'(o_ready), 64'd1);
    check("rst_a_resp",  64'(o_resp),  64'd0);
    check("rst_a_rdata", o_rdata,      64'd0);
    tgt = 2'd3;
    #0;
    check("rst_d_ready", 64'(o_ready), 64'd1);
    check("rst_d_rdata", o_rdata,      64'd0);
    cyc();
    rst_n   = 1'b1;
    rst_c_n = 1'b1;
    cyc();

    // ---- A: write then back-to-back read of the same word (forwarding) ----
    addr_phase(2'd0, 1'b1, 32'h100, 3'd2);
    cyc();
    hwdata = 64'h1122_3344;
    addr_phase(2'd0, 1'b0, 32'h100, 3'd2);
    @(negedge clk);
    check("fwd_wr_ready", 64'(o_ready), 64'd1);
    check("fwd_wr_rdata", o_rdata,      64'd0);
    cyc();
    bus_idle();
    hwdata = '0;
    @(negedge clk);
    check("fwd_rd_ready", 64'(o_ready), 64'd1);
    check("fwd_rd_rdata", o_rdata,      64'h1122_3344);
    cyc();
    @(negedge clk);
    check("fwd_after_rdata", o_rdata, 64'd0);
    u_a.read_word(32'h100, d32);
    check("fwd_mem", 64'(d32), 64'h1122_3344);
    cyc();

    // ---- A: byte and halfword lane writes --------------------------------
    u_a.write_word(32'h200, 32'hAABB_CCDD);
    xfer(2'd0, 1'b1, 32'h202, 3'd0, 64'h00EE_0000, rd, nw, r0, r1, wrd);
    check("byte_wr_nwait", 64'(nw), 64'd0);
    check("byte_wr_resp",  64'(r1), 64'd0);
    xfer(2'd0, 1'b0, 32'h200, 3'd2, 64'h0, rd, nw, r0, r1, wrd);
    check("byte_rd_data", rd, 64'hAAEE_CCDD);
    xfer(2'd0, 1'b1, 32'h200, 3'd1, 64'h0000_1234, rd, nw, r0, r1, wrd);
    xfer(2'd0, 1'b0, 32'h200, 3'd2, 64'h0, rd, nw, r0, r1, wrd);
    check("half_rd_data", rd, 64'hAAEE_1234);
    // a byte read still returns the whole word
    xfer(2'd0, 1'b0, 32'h201, 3'd0, 64'h0, rd, nw, r0, r1, wrd);
    check("byte_rd_fullword", rd, 64'hAAEE_1234);

    // ---- A: error responses ------------------------------------------------
    u_a.write_word(32'h0, 32'h5A5A_5A5A);
    xfer(2'd0, 1'b1, 32'h0004_0000, 3'd2, 64'hFFFF_FFFF, rd, nw, r0, r1, wrd);
    check("range_err_resp1", 64'(r0), 64'd1);
    check("range_err_nwait", 64'(nw), 64'd1);
    check("range_err_resp2", 64'(r1), 64'd1);
    u_a.read_word(32'h0, d32);
    check("range_err_mem", 64'(d32), 64'h5A5A_5A5A);

    xfer(2'd0, 1'b1, 32'h101, 3'd1, 64'hFFFF_FFFF, rd, nw, r0, r1, wrd);
    check("align_err_resp1", 64'(r0), 64'd1);
    check("align_err_nwait", 64'(nw), 64'd1);
    check("align_err_resp2", 64'(r1), 64'd1);
    u_a.read_word(32'h100, d32);
    check("align_err_mem", 64'(d32), 64'h1122_3344);

    xfer(2'd0, 1'b0, 32'h100, 3'd2, 64'h0, rd, nw, r0, r1, wrd);
    check("post_err_resp",  64'(r1), 64'd0);
    check("post_err_nwait", 64'(nw), 64'd0);
    check("post_err_rdata", rd,      64'h1122_3344);

    xfer(2'd0, 1'b0, 32'h8, 3'd3, 64'h0, rd, nw, r0, r1, wrd);
    check("size_err_resp1", 64'(r0), 64'd1);
    check("size_err_resp2", 64'(r1), 64'd1);
    check("size_err_rdata", rd,      64'd0);

    // ---- B: two wait states ------------------------------------------------
    u_b.write_word(32'h10, 32'hCAFE_0001);
    xfer(2'd1, 1'b0, 32'h10, 3'd2, 64'h0, rd, nw, r0, r1, wrd);
    check("ws2_rd_nwait", 64'(nw), 64'd2);
    check("ws2_rd_waitdata", wrd,  64'd0);
    check("ws2_rd_data",  rd,      64'hCAFE_0001);
    xfer(2'd1, 1'b1, 32'h10, 3'd2, 64'h0000_BEEF, rd, nw, r0, r1, wrd);
    check("ws2_wr_nwait", 64'(nw), 64'd2);
    u_b.read_word(32'h10, d32);
    check("ws2_wr_mem", 64'(d32), 64'h0000_BEEF);

    // ---- C: reset in the middle of a waited write -------------------------
    u_c.write_word(32'h20, 32'h1357_2468);
    addr_phase(2'd2, 1'b1, 32'h20, 3'd2);
    cyc();
    bus_idle();
    hwdata = 64'hFFFF_FFFF;
    @(negedge clk);
    check("ws3_wait_ready", 64'(o_ready), 64'd0);
    cyc();
    rst_c_n = 1'b0;
    cyc();
    rst_c_n = 1'b1;
    @(negedge clk);
    check("ws3_rst_ready", 64'(o_ready), 64'd1);
    check("ws3_rst_resp",  64'(o_resp),  64'd0);
    check("ws3_rst_rdata", o_rdata,      64'd0);
    repeat (5) cyc();
    hwdata = '0;
    u_c.read_word(32'h20, d32);
    check("ws3_rst_mem", 64'(d32), 64'h1357_2468);
    xfer(2'd2, 1'b0, 32'h20, 3'd2, 64'h0, rd, nw, r0, r1, wrd);
    check("ws3_rd_nwait", 64'(nw), 64'd3);
    check("ws3_rd_data",  rd,      64'h1357_2468);

    // ---- D: 64-bit lanes ---------------------------------------------------
    xfer(2'd3, 1'b1, 32'h8, 3'd3, 64'h0123_4567_89AB_CDEF, rd, nw, r0, r1, wrd);
    check("dw64_dw_resp", 64'(r1), 64'd0);
    xfer(2'd3, 1'b1, 32'hC, 3'd2, 64'hFFFF_FFFF_0000_0000, rd, nw, r0, r1, wrd);
    xfer(2'd3, 1'b0, 32'h8, 3'd3, 64'h0, rd, nw, r0, r1, wrd);
    check("dw64_rd_data", rd, 64'hFFFF_FFFF_89AB_CDEF);
    u_d.read_word(32'h8, d64);
    check("dw64_mem", d64, 64'hFFFF_FFFF_89AB_CDEF);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
